// File: rtl/state_polytomsg_masked_bitpack.sv
// rtl/state_polytomsg_masked_bitpack.sv - masked A2B, message-bit extraction and byte packing for poly_tomsg
module state_polytomsg_masked_bitpack #(
    parameter int KYBER_N    = 256,
    parameter int COEFF_SZ   = 16,
    parameter int QBITS2     = 13,
    parameter int A2B_LAT    = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int RAND_SZ    = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [COEFF_SZ-1:0] a1,
    input  logic [COEFF_SZ-1:0] a2,
    input  logic [RAND_SZ-1:0]  PRNG_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [7:0]          m1,
    output logic [7:0]          m2,
    output logic [4:0]          m_idx,
    output logic                done,
    output logic                overflow
);
    localparam int PW      = $clog2(FIFO_DEPTH);
    localparam int RESERVE = (A2B_LAT + 7) / 8 + 1;
    localparam int EW      = 8 + 8 + 5;
    localparam logic [PW:0] CNT_ONE  = (PW+1)'(1);
    localparam logic [PW:0] CNT_FULL = (PW+1)'(FIFO_DEPTH);
    localparam logic [PW:0] CNT_RES  = (PW+1)'(RESERVE);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
    state_t state, state_nxt;

    logic              accept, data_valid, push, pop, wr_en, fifo_full, clr;
    logic [8:0]        coeff_cnt;
    logic [4:0]        push_cnt, pop_cnt;
    logic [2:0]        bit_j;
    logic [7:0]        acc1, acc2, full1, full2;
    logic              push_pend;
    logic [QBITS2-1:0] a2b_r, a2b_sum;
    logic [QBITS2-1:0] pipe_b1 [A2B_LAT];
    logic [QBITS2-1:0] pipe_b2 [A2B_LAT];
    logic [A2B_LAT-1:0] pipe_v;
    logic              b1_bit, b2_bit;
    logic [EW-1:0]     mem [FIFO_DEPTH];
    logic [EW-1:0]     head, last_head;
    logic [PW-1:0]     rd_ptr, wr_ptr;
    logic [PW:0]       fifo_cnt;
    logic              unused_bits;

    assign accept  = in_valid & in_ready;
    assign clr     = (state == S_IDLE) & start;
    assign a2b_r   = PRNG_data[16 +: QBITS2];
    assign a2b_sum = a1[QBITS2-1:0] + a2[QBITS2-1:0];

    // A2B: b1 is fresh randomness, b2 = sum ^ b1, carried through a fixed-latency pipe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_v <= '0;
            for (int k = 0; k < A2B_LAT; k++) begin
                pipe_b1[k] <= '0;
                pipe_b2[k] <= '0;
            end
        end else begin
            pipe_v     <= {pipe_v[A2B_LAT-2:0], accept};
            pipe_b1[0] <= a2b_r;
            pipe_b2[0] <= a2b_sum ^ a2b_r;
            for (int k = 1; k < A2B_LAT; k++) begin
                pipe_b1[k] <= pipe_b1[k-1];
                pipe_b2[k] <= pipe_b2[k-1];
            end
        end
    end

    // Gating with the FSM flushes anything left in the pipe from an aborted run.
    assign data_valid = pipe_v[A2B_LAT-1] & ((state == S_RUN) | (state == S_DRAIN));
    assign b1_bit     = pipe_b1[A2B_LAT-1][QBITS2-1];
    assign b2_bit     = pipe_b2[A2B_LAT-1][QBITS2-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc1 <= '0; acc2 <= '0; full1 <= '0; full2 <= '0;
            bit_j <= '0; push_pend <= 1'b0;
        end else if (clr) begin
            acc1 <= '0; acc2 <= '0; full1 <= '0; full2 <= '0;
            bit_j <= '0; push_pend <= 1'b0;
        end else begin
            push_pend <= 1'b0;
            if (data_valid) begin
                bit_j <= bit_j + 3'd1;
                if (bit_j == 3'd7) begin
                    full1     <= {b1_bit, acc1[6:0]};
                    full2     <= {b2_bit, acc2[6:0]};
                    acc1      <= '0;
                    acc2      <= '0;
                    push_pend <= 1'b1;
                end else begin
                    acc1[bit_j] <= b1_bit;
                    acc2[bit_j] <= b2_bit;
                end
            end
        end
    end

    assign push = push_pend;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coeff_cnt <= '0; push_cnt <= '0; pop_cnt <= '0;
        end else if (clr) begin
            coeff_cnt <= '0; push_cnt <= '0; pop_cnt <= '0;
        end else begin
            if (accept) coeff_cnt <= coeff_cnt + 9'd1;
            if (push)   push_cnt  <= push_cnt + 5'd1;
            if (pop)    pop_cnt   <= pop_cnt + 5'd1;
        end
    end

    // First-word fall-through FIFO; outputs hold the last popped entry while empty.
    assign out_valid = (fifo_cnt != '0);
    assign fifo_full = (fifo_cnt == CNT_FULL);
    assign pop       = out_valid & out_ready;
    assign wr_en     = push & (~fifo_full | pop);
    assign head      = mem[rd_ptr];
    assign {m1, m2, m_idx} = out_valid ? head : last_head;

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= {full1 ^ PRNG_data[7:0], full2 ^ PRNG_data[7:0], push_cnt};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0; wr_ptr <= '0; fifo_cnt <= '0;
            last_head <= '0; overflow <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr    <= rd_ptr + 1'b1;
                last_head <= head;
            end
            if (wr_en & ~pop)      fifo_cnt <= fifo_cnt + CNT_ONE;
            else if (~wr_en & pop) fifo_cnt <= fifo_cnt - CNT_ONE;
            if (push & fifo_full & ~pop) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_RUN;
            S_RUN:   if (accept && coeff_cnt == 9'(KYBER_N - 1)) state_nxt = S_DRAIN;
            S_DRAIN: if (pop && pop_cnt == 5'(KYBER_N / 8 - 1)) state_nxt = S_DONE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        done     = 1'b0;
        if (state == S_RUN)  in_ready = ((CNT_FULL - fifo_cnt) > CNT_RES);
        if (state == S_DONE) done = 1'b1;
    end

    assign unused_bits = ^{a1[COEFF_SZ-1:QBITS2], a2[COEFF_SZ-1:QBITS2], PRNG_data[RAND_SZ-1:16+QBITS2],
                           PRNG_data[15:8], pipe_b1[A2B_LAT-1][QBITS2-2:0], pipe_b2[A2B_LAT-1][QBITS2-2:0]};
endmodule

// File: tb/tb_state_polytomsg_masked_bitpack.sv
// tb/tb_state_polytomsg_masked_bitpack.sv - randomized self-checking bench for the masked bit packer
module tb_state_polytomsg_masked_bitpack;
    localparam int N = 256;

    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [15:0] a1 = '0, a2 = '0;
    logic [31:0] prng = '0;
    logic        in_ready, out_valid, done, overflow;
    logic [7:0]  m1, m2;
    logic [4:0]  m_idx;

    int errors = 0, checks = 0, cyc = 0, done_cnt = 0;
    logic [7:0]  pop_m1[$], pop_m2[$];
    logic [4:0]  pop_idx[$];
    logic [15:0] ca1 [N], ca2 [N];
    logic [7:0]  prev_m1 [32];

    state_polytomsg_masked_bitpack dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .a1(a1), .a2(a2), .PRNG_data(prng), .out_valid(out_valid), .out_ready(out_ready),
        .m1(m1), .m2(m2), .m_idx(m_idx), .done(done), .overflow(overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial forever begin
        @(posedge clk);
        #1 prng = $urandom;
    end

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            pop_m1.push_back(m1);
            pop_m2.push_back(m2);
            pop_idx.push_back(m_idx);
        end
        if (rst_n && done) done_cnt = done_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // mode: 0 out_ready=1, 1 random out_ready, 2 out_ready=0 until input stalls
    task automatic run_poly(input int mode, input int stop_at, input bit proto,
                            input bit special, input bit rnd_bits, input bit mask_cmp);
        int i, guard, stall, base, base_done, acc7, first_ov, n_pop, ir_drain, leak, diff, s;
        bit acc, rel, bp_seen, want;
        logic [12:0] v, lo;
        logic [7:0] exp_b [32];
        for (int k = 0; k < N; k++) begin
            want   = rnd_bits ? 1'($urandom) : 1'(k & 1);
            v      = {want, 12'($urandom)};
            ca1[k] = 16'($urandom);
            lo     = v - ca1[k][12:0];
            ca2[k] = {3'($urandom), lo};
        end
        if (special) begin
            ca1[0] = 16'h0FFF; ca2[0] = 16'h0001;
            ca1[1] = 16'h1FFF; ca2[1] = 16'h0001;
            ca1[2] = 16'hF000; ca2[2] = 16'h0000;
        end
        for (int b = 0; b < 32; b++) exp_b[b] = 8'h00;
        for (int k = 0; k < N; k++) begin
            s = (int'(ca1[k]) & 'h1FFF) + (int'(ca2[k]) & 'h1FFF);
            exp_b[k / 8][k % 8] = 1'((s >> 12) & 1);
        end

        base = pop_m1.size(); base_done = done_cnt;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        out_ready = (mode == 2) ? 1'b0 : 1'b1;
        i = 0; guard = 0; stall = 0; acc7 = 0; first_ov = -1; rel = 0; bp_seen = 0;
        while (i < stop_at && guard < 20000) begin
            in_valid = 1'b1; a1 = ca1[i]; a2 = ca2[i];
            start = proto && (i == 50);
            if (rel) out_ready = 1'b1;
            else if (mode == 1) out_ready = 1'($urandom);
            @(negedge clk);
            acc = in_ready;
            if (out_valid && first_ov < 0) first_ov = cyc;
            if (acc && i == 7) acc7 = cyc;
            if (mode == 2 && !rel) begin
                stall = acc ? 0 : stall + 1;
                if (stall >= 40) begin
                    chk("bp_overflow", overflow, 0);
                    chk("bp_head_valid", out_valid, 1);
                    bp_seen = 1; rel = 1;
                end
            end
            @(posedge clk); #1;
            if (acc) i++;
            guard++;
        end
        in_valid = proto; start = 1'b0;

        if (stop_at < N) begin
            n_pop = pop_m1.size();
            rst_n = 1'b0; in_valid = 1'b0;
            @(negedge clk);
            chk("rst_in_ready", in_ready, 0);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_m1", m1, 0);
            chk("rst_m2", m2, 0);
            chk("rst_m_idx", m_idx, 0);
            chk("rst_done", done, 0);
            chk("rst_overflow", overflow, 0);
            repeat (3) @(posedge clk);
            #1 rst_n = 1'b1;
            repeat (30) @(posedge clk);
            @(negedge clk);
            chk("rst_no_emit", pop_m1.size() - n_pop, 0);
            chk("rst_idle_valid", out_valid, 0);
            return;
        end

        chk("feed_bound", guard < 20000, 1);
        if (mode == 2) chk("bp_stall", bp_seen, 1);
        if (mode == 0 && special) chk("latency", first_ov - acc7, 10);

        guard = 0; ir_drain = 0;
        while (done_cnt == base_done && guard < 3000) begin
            out_ready = (mode == 1) ? 1'($urandom) : 1'b1;
            @(negedge clk);
            if (in_ready) ir_drain++;
            @(posedge clk); #1;
            guard++;
        end
        chk("done_bound", guard < 3000, 1);
        repeat (5) @(posedge clk);
        #1;
        chk("done_once", done_cnt - base_done, 1);
        if (proto) chk("in_ready_drain", ir_drain, 0);
        chk("overflow", overflow, 0);
        in_valid = 1'b0; out_ready = 1'b1;

        n_pop = pop_m1.size() - base;
        chk("pop_count", n_pop, 32);
        leak = 0; diff = 0;
        for (int b = 0; b < n_pop && b < 32; b++) begin
            chk($sformatf("byte%0d", b), pop_m1[base+b] ^ pop_m2[base+b], exp_b[b]);
            chk($sformatf("m_idx%0d", b), pop_idx[base+b], b);
            if (pop_m1[base+b] == exp_b[b]) leak++;
            if (pop_m1[base+b] != prev_m1[b]) diff++;
            prev_m1[b] = pop_m1[base+b];
        end
        if (special && n_pop > 0) begin
            chk("single_0fff_0001", pop_m1[base][0] ^ pop_m2[base][0], 1);
            chk("single_1fff_0001", pop_m1[base][1] ^ pop_m2[base][1], 0);
            chk("single_f000_0000", pop_m1[base][2] ^ pop_m2[base][2], 1);
        end
        if (mask_cmp) begin
            chk("mask_m1_differs", diff > 0, 1);
            chk("mask_no_plain", leak < 4, 1);
        end
    endtask

    initial begin
        for (int b = 0; b < 32; b++) prev_m1[b] = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_in_ready", in_ready, 0);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_m1", m1, 0);
        chk("reset_m2", m2, 0);
        chk("reset_m_idx", m_idx, 0);
        chk("reset_done", done, 0);
        chk("reset_overflow", overflow, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        run_poly(0, N, 0, 1, 1, 0);
        run_poly(0, N, 0, 0, 0, 0);
        run_poly(1, N, 0, 0, 0, 1);
        run_poly(2, N, 0, 0, 1, 0);
        run_poly(0, 100, 0, 0, 1, 0);
        run_poly(0, N, 0, 0, 1, 0);
        run_poly(1, N, 1, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
